// File: rtl/perturbation_ctrl_slave_pkg.sv
// Shared types, register offsets and constants for the perturbation control slave.
package perturbation_ctrl_slave_pkg;

  typedef enum logic [31:0] {
    STANDARD = 32'd1,
    RANDOM   = 32'd2,
    PC_TRIG  = 32'd3
  } pert_mode_e;

  // Byte offsets within the 32-byte register window (addr[4:2] decoded)
  localparam logic [4:0] MODE_OFF     = 5'h00;
  localparam logic [4:0] PCTRIG_OFF   = 5'h04;
  localparam logic [4:0] STALLMAX_OFF = 5'h08;
  localparam logic [4:0] SEED_OFF     = 5'h0C;
  localparam logic [4:0] HITCNT_OFF   = 5'h10;
  localparam logic [4:0] STATUS_OFF   = 5'h14;

  // Galois feedback taps for the right-shifting 32-bit LFSR
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // True for the three mode codes software is allowed to write
  function automatic logic mode_legal(input logic [31:0] value);
    return (value == 32'(STANDARD)) || (value == 32'(RANDOM)) || (value == 32'(PC_TRIG));
  endfunction

endpackage

// File: rtl/perturbation_ctrl_slave_if.sv
// TB data bus as seen by the perturbation control slave: request/grant plus one-cycle response.
interface perturbation_ctrl_slave_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/perturbation_ctrl_slave_lfsr.sv
// 32-bit Galois LFSR (shift right) with synchronous seed load and advance enable.
module perturbation_lfsr
  import perturbation_ctrl_slave_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        en,
  output logic [31:0] state
);

  logic [31:0] state_next;

  // Next state of one Galois step
  always_comb begin
    state_next = {1'b0, state[31:1]};
    if (state[0]) state_next = state_next ^ LFSR_TAPS;
  end

  // State register: a seed load takes priority over advancing
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       state <= SEED;
    else if (load) state <= load_value;
    else if (en)   state <= state_next;
  end

endmodule

// File: rtl/perturbation_ctrl_slave.sv
// Memory-mapped perturbation configuration slave: register file, bus response,
// PC-trigger hit tracking and the combinational stall value for the consumer.
module perturbation_ctrl_slave
  import perturbation_ctrl_slave_pkg::*;
#(
  parameter int unsigned STALL_W      = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'hACE1_2468
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  perturbation_ctrl_slave_if.slave   bus,
  input  logic [31:0]                pc_i,
  input  logic                       pc_valid_i,
  input  logic                       stall_ack_i,
  output logic [31:0]                mode_o,
  output logic [STALL_W-1:0]         stall_value_o,
  output logic                       pc_trig_hit_o
);

  pert_mode_e          mode_q, mode_d;
  logic [31:0]         pc_trig_addr_q, pc_trig_addr_d;
  logic [STALL_W-1:0]  stall_max_q, stall_max_d;
  logic [31:0]         hit_count_q;
  logic                status_q;
  logic                hit_flag_q;
  logic                hit_pulse_q;

  logic [4:0]          off;
  logic [31:0]         be_mask;
  logic [31:0]         stall_max_ext;
  logic [31:0]         stall_max_merged;
  logic                status_set, status_clr, hit_clr, seed_load;
  logic [31:0]         seed_value;
  logic                resp_err;
  logic [31:0]         resp_rdata;
  logic                hit_now;
  logic [31:0]         lfsr_state;
  logic [STALL_W-1:0]  rand_raw;

  assign bus.gnt       = bus.req;
  assign off           = {bus.addr[4:2], 2'b00};
  assign stall_max_ext = 32'(stall_max_q);
  assign seed_value    = (bus.wdata == '0) ? SEED_DEFAULT : bus.wdata;
  assign hit_now       = pc_valid_i && (pc_i == pc_trig_addr_q) && (mode_q == PC_TRIG);
  assign mode_o        = mode_q;
  assign pc_trig_hit_o = hit_pulse_q;
  assign rand_raw      = lfsr_state[STALL_W-1:0];

  // Expand byte enables into a bit mask
  always_comb begin
    be_mask = '0;
    for (int unsigned i = 0; i < 4; i++) be_mask[8*i +: 8] = {8{bus.be[i]}};
  end

  // Register decode: next register values, side-effect strobes and response data
  always_comb begin
    mode_d           = mode_q;
    pc_trig_addr_d   = pc_trig_addr_q;
    stall_max_d      = stall_max_q;
    stall_max_merged = (stall_max_ext & ~be_mask) | (bus.wdata & be_mask);
    status_set       = 1'b0;
    status_clr       = 1'b0;
    hit_clr          = 1'b0;
    seed_load        = 1'b0;
    resp_err         = 1'b0;
    resp_rdata       = '0;
    if (bus.req) begin
      case (off)
        MODE_OFF: begin
          if (bus.we) begin
            if (bus.be == 4'hF && mode_legal(bus.wdata)) begin
              mode_d = pert_mode_e'(bus.wdata);
            end else begin
              resp_err   = 1'b1;
              status_set = 1'b1;
            end
          end else begin
            resp_rdata = mode_q;
          end
        end
        PCTRIG_OFF: begin
          if (bus.we) pc_trig_addr_d = (pc_trig_addr_q & ~be_mask) | (bus.wdata & be_mask);
          else        resp_rdata     = pc_trig_addr_q;
        end
        STALLMAX_OFF: begin
          if (bus.we) stall_max_d = stall_max_merged[STALL_W-1:0];
          else        resp_rdata  = stall_max_ext;
        end
        SEED_OFF: begin
          if (bus.we) seed_load = 1'b1;
        end
        HITCNT_OFF: begin
          if (bus.we) hit_clr    = 1'b1;
          else        resp_rdata = hit_count_q;
        end
        STATUS_OFF: begin
          if (bus.we) status_clr = 1'b1;
          else        resp_rdata = {31'b0, status_q};
        end
        default: resp_err = 1'b1;
      endcase
    end
  end

  // Configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q         <= STANDARD;
      pc_trig_addr_q <= '0;
      stall_max_q    <= '0;
      status_q       <= 1'b0;
    end else begin
      mode_q         <= mode_d;
      pc_trig_addr_q <= pc_trig_addr_d;
      stall_max_q    <= stall_max_d;
      if (status_set)      status_q <= 1'b1;
      else if (status_clr) status_q <= 1'b0;
    end
  end

  // Bus response: exactly one registered rvalid per granted request
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
      bus.rdata  <= '0;
    end else begin
      bus.rvalid <= bus.req;
      bus.err    <= resp_err;
      bus.rdata  <= resp_rdata;
    end
  end

  // PC-trigger tracking; the flag is cleared using the incoming mode so that
  // leaving PC_TRIG never carries a stale hit into a later re-entry
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_flag_q  <= 1'b0;
      hit_pulse_q <= 1'b0;
      hit_count_q <= '0;
    end else begin
      hit_pulse_q <= hit_now;
      if (mode_d != PC_TRIG) hit_flag_q <= 1'b0;
      else if (hit_now)      hit_flag_q <= 1'b1;
      else if (stall_ack_i)  hit_flag_q <= 1'b0;
      if (hit_clr)                          hit_count_q <= '0;
      else if (hit_now && hit_count_q != '1) hit_count_q <= hit_count_q + 32'd1;
    end
  end

  // Stall value offered to the consumer for its next request
  always_comb begin
    stall_value_o = '0;
    case (mode_q)
      STANDARD: stall_value_o = stall_max_q;
      RANDOM:   stall_value_o = (rand_raw > stall_max_q) ? (rand_raw & stall_max_q) : rand_raw;
      PC_TRIG:  stall_value_o = hit_flag_q ? stall_max_q : '0;
      default:  stall_value_o = '0;
    endcase
  end

  perturbation_lfsr #(
    .SEED(SEED_DEFAULT)
  ) u_lfsr (
    .clk        (clk_i),
    .rst        (rst_i),
    .load       (seed_load),
    .load_value (seed_value),
    .en         (stall_ack_i),
    .state      (lfsr_state)
  );

endmodule

// File: tb/tb_perturbation_ctrl_slave.sv
// Directed bench for perturbation_ctrl_slave with hand-computed expectations.
module tb_perturbation_ctrl_slave;

  localparam logic [31:0] SEED    = 32'hACE1_2468;
  localparam logic [31:0] PC_HIT  = 32'h1C00_8080;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] pc_i = '0;
  logic        pc_valid_i = 1'b0;
  logic        stall_ack_i = 1'b0;
  logic [31:0] mode_o;
  logic [7:0]  stall_value_o;
  logic        pc_trig_hit_o;

  int n_checks = 0;
  int n_errors = 0;

  perturbation_ctrl_slave_if bus ();

  perturbation_ctrl_slave #(
    .STALL_W      (8),
    .SEED_DEFAULT (SEED)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus           (bus),
    .pc_i          (pc_i),
    .pc_valid_i    (pc_valid_i),
    .stall_ack_i   (stall_ack_i),
    .mode_o        (mode_o),
    .stall_value_o (stall_value_o),
    .pc_trig_hit_o (pc_trig_hit_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [7:0] rand_exp(input logic [31:0] s, input logic [7:0] max);
    logic [7:0] r;
    r = s[7:0];
    return (r > max) ? (r & max) : r;
  endfunction

  // Present a request right after a falling edge and confirm the grant
  task automatic req_set(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.be    = be;
    bus.wdata = wdata;
    #1;
    check("gnt", 32'(bus.gnt), 32'd1);
  endtask

  task automatic req_clr();
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic check_resp(input string tag, input logic [31:0] rdata, input logic err);
    check({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    check({tag, "_rdata"},  bus.rdata, rdata);
    check({tag, "_err"},    32'(bus.err), 32'(err));
  endtask

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk_i);
    req_set(we, addr, be, wdata);
    @(negedge clk_i);
    req_clr();
    check_resp(tag, exp_rdata, exp_err);
  endtask

  logic [31:0] s;
  logic [7:0]  seq [20];
  logic [255:0] seen;
  int distinct;

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.be = '0; bus.wdata = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    // 1: reset state and first reads
    #1;
    check("rst_gnt",    32'(bus.gnt), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_rdata",  bus.rdata, 32'd0);
    check("rst_err",    32'(bus.err), 32'd0);
    check("rst_hit",    32'(pc_trig_hit_o), 32'd0);
    check("rst_mode",   mode_o, 32'd1);
    check("rst_stall",  32'(stall_value_o), 32'd0);
    access("rd_mode", 1'b0, 32'h00, 4'hF, '0, 32'd1, 1'b0);
    @(negedge clk_i);
    check("idle_rvalid", 32'(bus.rvalid), 32'd0);
    access("rd_smax", 1'b0, 32'h08, 4'hF, '0, 32'd0, 1'b0);

    // 2: illegal mode writes, sticky status, unmapped offsets
    access("wr_mode5", 1'b1, 32'h00, 4'hF, 32'd5, 32'd0, 1'b1);
    check("mode_kept", mode_o, 32'd1);
    access("rd_stat1", 1'b0, 32'h14, 4'hF, '0, 32'd1, 1'b0);
    access("wr_stat",  1'b1, 32'h14, 4'hF, 32'd0, 32'd0, 1'b0);
    access("rd_stat0", 1'b0, 32'h14, 4'hF, '0, 32'd0, 1'b0);
    access("wr_mode_be", 1'b1, 32'h00, 4'h3, 32'd2, 32'd0, 1'b1);
    check("mode_kept2", mode_o, 32'd1);
    access("wr_stat2", 1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF, 32'd0, 1'b0);
    access("rd_18", 1'b0, 32'h18, 4'hF, '0, 32'd0, 1'b1);
    access("wr_1c", 1'b1, 32'h1C, 4'hF, 32'h1234_5678, 32'd0, 1'b1);

    // 3: random mode bounded by STALL_MAX, seed reload
    access("wr_smax", 1'b1, 32'h08, 4'hF, 32'hFFFF_FF07, 32'd0, 1'b0);
    access("rd_smax7", 1'b0, 32'h08, 4'hF, '0, 32'd7, 1'b0);
    check("std_stall", 32'(stall_value_o), 32'd7);
    access("wr_mode2", 1'b1, 32'h00, 4'hF, 32'd2, 32'd0, 1'b0);
    check("mode_rand", mode_o, 32'd2);
    s = SEED;
    seen = '0;
    for (int i = 0; i < 1000; i++) begin
      check("rand_val", 32'(stall_value_o), 32'(rand_exp(s, 8'd7)));
      seen[stall_value_o] = 1'b1;
      if (i < 20) seq[i] = stall_value_o;
      stall_ack_i = 1'b1;
      @(negedge clk_i);
      s = lfsr_next(s);
    end
    stall_ack_i = 1'b0;
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    check("rand_le7", 32'(seen[255:8] == '0), 32'd1);
    check("rand_distinct", 32'(distinct >= 4), 32'd1);
    access("wr_seed0", 1'b1, 32'h0C, 4'hF, 32'd0, 32'd0, 1'b0);
    access("rd_seed", 1'b0, 32'h0C, 4'hF, '0, 32'd0, 1'b0);
    s = SEED;
    for (int i = 0; i < 20; i++) begin
      check("reseed_model", 32'(stall_value_o), 32'(rand_exp(s, 8'd7)));
      check("reseed_repeat", 32'(stall_value_o), 32'(seq[i]));
      stall_ack_i = 1'b1;
      @(negedge clk_i);
      s = lfsr_next(s);
    end
    stall_ack_i = 1'b0;
    access("wr_seed5", 1'b1, 32'h0C, 4'hF, 32'd5, 32'd0, 1'b0);
    check("seed5_val", 32'(stall_value_o), 32'd5);
    stall_ack_i = 1'b1;
    @(negedge clk_i);
    stall_ack_i = 1'b0;
    check("seed5_next", 32'(stall_value_o), 32'd1);

    // 4: PC trigger
    access("wr_smax5", 1'b1, 32'h08, 4'hF, 32'd5, 32'd0, 1'b0);
    access("wr_pctrig", 1'b1, 32'h04, 4'hF, PC_HIT, 32'd0, 1'b0);
    access("wr_mode3", 1'b1, 32'h00, 4'hF, 32'd3, 32'd0, 1'b0);
    check("pc_idle_stall", 32'(stall_value_o), 32'd0);
    pc_i = PC_HIT + 32'd4; pc_valid_i = 1'b1;
    @(negedge clk_i);
    pc_valid_i = 1'b0;
    check("pc_miss_hit", 32'(pc_trig_hit_o), 32'd0);
    pc_i = PC_HIT; pc_valid_i = 1'b1;
    #1;
    check("pc_hit_early", 32'(pc_trig_hit_o), 32'd0);
    @(negedge clk_i);
    pc_valid_i = 1'b0;
    check("pc_hit", 32'(pc_trig_hit_o), 32'd1);
    check("pc_stall", 32'(stall_value_o), 32'd5);
    @(negedge clk_i);
    check("pc_hit_pulse", 32'(pc_trig_hit_o), 32'd0);
    check("pc_stall_hold", 32'(stall_value_o), 32'd5);
    stall_ack_i = 1'b1;
    @(negedge clk_i);
    stall_ack_i = 1'b0;
    check("pc_stall_acked", 32'(stall_value_o), 32'd0);
    access("rd_hit1", 1'b0, 32'h10, 4'hF, '0, 32'd1, 1'b0);

    // 5: coincident hit with HIT_COUNT write, and with stall_ack
    @(negedge clk_i);
    req_set(1'b1, 32'h10, 4'hF, 32'd0);
    pc_valid_i = 1'b1;
    @(negedge clk_i);
    req_clr();
    pc_valid_i = 1'b0;
    check_resp("wr_hitcnt", 32'd0, 1'b0);
    check("coinc_hit", 32'(pc_trig_hit_o), 32'd1);
    access("rd_hit0", 1'b0, 32'h10, 4'hF, '0, 32'd0, 1'b0);
    check("coinc_stall", 32'(stall_value_o), 32'd5);
    stall_ack_i = 1'b1;
    @(negedge clk_i);
    stall_ack_i = 1'b0;
    check("ack_clear", 32'(stall_value_o), 32'd0);
    pc_valid_i = 1'b1; stall_ack_i = 1'b1;
    @(negedge clk_i);
    pc_valid_i = 1'b0; stall_ack_i = 1'b0;
    check("set_wins", 32'(stall_value_o), 32'd5);
    access("rd_hit_again", 1'b0, 32'h10, 4'hF, '0, 32'd1, 1'b0);
    access("wr_mode1", 1'b1, 32'h00, 4'hF, 32'd1, 32'd0, 1'b0);
    check("std_stall5", 32'(stall_value_o), 32'd5);
    access("wr_mode3b", 1'b1, 32'h00, 4'hF, 32'd3, 32'd0, 1'b0);
    check("flag_dropped", 32'(stall_value_o), 32'd0);

    // 6: back-to-back write/read after reset, then reset with a read pending
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    req_set(1'b1, 32'h04, 4'b0011, 32'hDEAD_BEEF);
    @(negedge clk_i);
    check_resp("b2b_wr", 32'd0, 1'b0);
    req_set(1'b0, 32'h04, 4'hF, 32'd0);
    @(negedge clk_i);
    req_clr();
    check_resp("b2b_rd", 32'h0000_BEEF, 1'b0);
    access("pre_mode", 1'b1, 32'h00, 4'hF, 32'd2, 32'd0, 1'b0);
    access("pre_smax", 1'b1, 32'h08, 4'hF, 32'd9, 32'd0, 1'b0);
    @(negedge clk_i);
    req_set(1'b0, 32'h00, 4'hF, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    req_clr();
    #1;
    check("rst_drop", 32'(bus.rvalid), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("post_rst_rvalid", 32'(bus.rvalid), 32'd0);
    end
    check("post_rst_mode", mode_o, 32'd1);
    check("post_rst_stall", 32'(stall_value_o), 32'd0);
    access("post_mode",  1'b0, 32'h00, 4'hF, '0, 32'd1, 1'b0);
    access("post_pctrg", 1'b0, 32'h04, 4'hF, '0, 32'd0, 1'b0);
    access("post_smax",  1'b0, 32'h08, 4'hF, '0, 32'd0, 1'b0);
    access("post_hit",   1'b0, 32'h10, 4'hF, '0, 32'd0, 1'b0);
    access("post_stat",  1'b0, 32'h14, 4'hF, '0, 32'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
